// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the program-counter unit.
// The next-PC select enum, default width/step values and a log2 helper
// used to size the return-stack pointer.
package pc_pkg;

    typedef enum logic [2:0] {
        SEL_SEQ    = 3'd0,
        SEL_BRANCH = 3'd1,
        SEL_CALL   = 3'd2,
        SEL_JUMP   = 3'd3,
        SEL_RETURN = 3'd4
    } pc_sel_e;

    localparam int PC_WIDTH_DEF = 32;
    localparam int PC_STEP_DEF  = 4;

    // Smallest r with 2**r >= depth; depth is a power of two >= 2.
    function automatic int log2_depth(input int depth);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < depth) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pc_unit_add.sv
// ADD: constant-operand adder, Y = A + B modulo 2**WIDTH.
// Used by pc_unit as the sequential-step incrementer.
module ADD #(
    parameter int WIDTH = 32,
    parameter int B     = 4
) (
    input  logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] Y
);

    localparam logic [WIDTH-1:0] B_VEC = WIDTH'(B);

    assign Y = A + B_VEC;

endmodule

// File: rtl/pc_unit_return_stack.sv
// return_stack: circular LIFO of return addresses for pc_unit.
// A push when full overwrites the oldest entry and the count saturates at
// DEPTH. A pop on an empty stack is ignored. Push wins if both are raised,
// although the owner never raises both together.
module return_stack
    import pc_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH_DEF,
    parameter int DEPTH = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Push,
    input  logic             Pop,
    input  logic [WIDTH-1:0] PushData,
    output logic [WIDTH-1:0] Top,
    output logic             Empty,
    output logic             Full
);

    localparam int            AW       = log2_depth(DEPTH);
    localparam logic [AW-1:0] ONE_IDX  = AW'(1);
    localparam logic [AW:0]   ONE_CNT  = (AW+1)'(1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    ptr_r;     // next slot to write
    logic [AW:0]      count_r;
    logic [AW-1:0]    top_idx_s;

    assign top_idx_s = ptr_r - ONE_IDX;
    assign Top       = mem_r[top_idx_s];
    assign Empty     = (count_r == '0);
    assign Full      = (count_r == FULL_CNT);

    // Pointer and occupancy count; reset discards every entry.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ptr_r   <= '0;
            count_r <= '0;
        end else if (Push) begin
            ptr_r   <= ptr_r + ONE_IDX;
            count_r <= Full ? count_r : (count_r + ONE_CNT);
        end else if (Pop && !Empty) begin
            ptr_r   <= top_idx_s;
            count_r <= count_r - ONE_CNT;
        end else begin
            ptr_r   <= ptr_r;
            count_r <= count_r;
        end
    end

    // Entry storage; contents are don't-care until pushed.
    always_ff @(posedge Clock) begin
        if (Push && !Reset) begin
            mem_r[ptr_r] <= PushData;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter.
// Sequential advance by STEP, redirects with priority
// Branch > Call > Jump > Return > sequential, stall via Enable, and an
// optional return-address stack built only when PC_RAS_EN is defined.
// Without PC_RAS_EN, Call behaves as Jump and Return is ignored.
module pc_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH        = PC_WIDTH_DEF,
    parameter int               STEP         = PC_STEP_DEF,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             BranchTaken,
    input  logic [WIDTH-1:0] BranchTarget,
    input  logic             Jump,
    input  logic             Call,
    input  logic             Return,
    input  logic [WIDTH-1:0] JumpTarget,
    output logic [WIDTH-1:0] Out,
    output logic [WIDTH-1:0] OutPlusStep,
    output logic             RasEmpty,
    output logic             RasFull,
    output logic             Underflow
);

    logic [WIDTH-1:0] out_r;
    logic [WIDTH-1:0] plus_step_s;
    logic [WIDTH-1:0] next_pc_s;
    logic [WIDTH-1:0] ras_top_s;
    logic             ras_empty_s;
    logic             ras_full_s;
    logic             ret_req_s;
    logic             push_s;
    logic             pop_s;
    logic             underflow_next_s;
    logic             underflow_r;
    pc_sel_e          sel_s;

    ADD #(.WIDTH(WIDTH), .B(STEP)) u_inc (
        .A (out_r),
        .Y (plus_step_s)
    );

`ifdef PC_RAS_EN
    assign ret_req_s = Return;

    return_stack #(.WIDTH(WIDTH), .DEPTH(RAS_DEPTH)) u_ras (
        .Clock    (Clock),
        .Reset    (Reset),
        .Push     (push_s),
        .Pop      (pop_s),
        .PushData (plus_step_s),
        .Top      (ras_top_s),
        .Empty    (ras_empty_s),
        .Full     (ras_full_s)
    );
`else
    logic ras_unused_s;
    assign ret_req_s    = 1'b0;
    assign ras_top_s    = '0;
    assign ras_empty_s  = 1'b1;
    assign ras_full_s   = 1'b0;
    assign ras_unused_s = ^{Return, push_s, pop_s, 32'(RAS_DEPTH)};
`endif

    // Priority select of the next-PC source and the stack side effects.
    always_comb begin
        sel_s            = SEL_SEQ;
        next_pc_s        = plus_step_s;
        if (BranchTaken) begin
            sel_s = SEL_BRANCH;
        end else if (Call) begin
            sel_s = SEL_CALL;
        end else if (Jump) begin
            sel_s = SEL_JUMP;
        end else if (ret_req_s) begin
            sel_s = SEL_RETURN;
        end else begin
            sel_s = SEL_SEQ;
        end
        case (sel_s)
            SEL_SEQ:    next_pc_s = plus_step_s;
            SEL_BRANCH: next_pc_s = BranchTarget;
            SEL_CALL:   next_pc_s = JumpTarget;
            SEL_JUMP:   next_pc_s = JumpTarget;
            SEL_RETURN: next_pc_s = ras_empty_s ? plus_step_s : ras_top_s;
            default:    next_pc_s = plus_step_s;
        endcase
        push_s           = Enable && (sel_s == SEL_CALL) && !Reset;
        pop_s            = Enable && (sel_s == SEL_RETURN) && !ras_empty_s && !Reset;
        underflow_next_s = Enable && (sel_s == SEL_RETURN) && ras_empty_s;
    end

    // PC register: reset overrides everything, stall holds.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            out_r <= RESET_VECTOR;
        end else if (Enable) begin
            out_r <= next_pc_s;
        end else begin
            out_r <= out_r;
        end
    end

    // One-cycle underflow pulse; a stalled cycle clears it.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            underflow_r <= 1'b0;
        end else begin
            underflow_r <= underflow_next_s;
        end
    end

    assign Out         = out_r;
    assign OutPlusStep = plus_step_s;
    assign RasEmpty    = ras_empty_s;
    assign RasFull     = ras_full_s;
    assign Underflow   = underflow_r;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: table-driven bench for pc_unit with a scoreboard queue.
// Covers both builds; RAS sequences are selected with PC_RAS_EN.
module tb_pc_unit;

    logic        clk;
    logic        rst, en, br, jmp, call, ret;
    logic [31:0] bt, jt;
    logic [31:0] out_w, ops_w;
    logic        empty_w, full_w, uf_w;

    typedef struct {
        string       name;
        logic        rst, en, br, jmp, call, ret;
        logic [31:0] bt, jt;
        logic [31:0] exp_out;
        logic        exp_empty, exp_full, exp_uf;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] out;
        logic        empty, full, uf;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    pc_unit #(.WIDTH(32), .STEP(4), .RESET_VECTOR(32'h0), .RAS_DEPTH(4)) dut (
        .Clock        (clk),
        .Reset        (rst),
        .Enable       (en),
        .BranchTaken  (br),
        .BranchTarget (bt),
        .Jump         (jmp),
        .Call         (call),
        .Return       (ret),
        .JumpTarget   (jt),
        .Out          (out_w),
        .OutPlusStep  (ops_w),
        .RasEmpty     (empty_w),
        .RasFull      (full_w),
        .Underflow    (uf_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t v(string n, logic r, logic e, logic b, logic j,
                               logic c, logic rt, logic [31:0] bta,
                               logic [31:0] jta, logic [31:0] o,
                               logic emp, logic ful, logic u);
        vec_t x;
        x.name = n; x.rst = r; x.en = e; x.br = b; x.jmp = j; x.call = c;
        x.ret = rt; x.bt = bta; x.jt = jta; x.exp_out = o;
        x.exp_empty = emp; x.exp_full = ful; x.exp_uf = u;
        return x;
    endfunction

    task automatic check(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; br = 1'b0; jmp = 1'b0; call = 1'b0; ret = 1'b0;
        bt = 32'h0; jt = 32'h0;

        // name, rst, en, br, jmp, call, ret, bt, jt, out, empty, full, uf
        vecs.push_back(v("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0));
        for (int i = 1; i <= 10; i++)
            vecs.push_back(v("seq", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'(4 * i), 1'b1, 1'b0, 1'b0));
        vecs.push_back(v("stall1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h77, 32'h0, 32'd40, 1'b1, 1'b0, 1'b0));
        vecs.push_back(v("stall2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h88, 32'd40, 1'b1, 1'b0, 1'b0));
        vecs.push_back(v("jump100", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h100, 32'h100, 1'b1, 1'b0, 1'b0));
        vecs.push_back(v("br_over_jmp", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h200, 32'h300, 32'h200, 1'b1, 1'b0, 1'b0));
        vecs.push_back(v("jump_top", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0));
        vecs.push_back(v("wrap", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(v("br_over_call", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h500, 32'h600, 32'h500, 1'b1, 1'b0, 1'b0));
        vecs.push_back(v("unaligned", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h123, 32'h0, 32'h123, 1'b1, 1'b0, 1'b0));
        vecs.push_back(v("jump100b", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h100, 32'h100, 1'b1, 1'b0, 1'b0));
`ifdef PC_RAS_EN
        vecs.push_back(v("call400", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h400, 32'h400, 1'b0, 1'b0, 1'b0));
        vecs.push_back(v("s404", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h404, 1'b0, 1'b0, 1'b0));
        vecs.push_back(v("s408", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h408, 1'b0, 1'b0, 1'b0));
        vecs.push_back(v("s40c", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h40C, 1'b0, 1'b0, 1'b0));
        vecs.push_back(v("ret104", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h104, 1'b1, 1'b0, 1'b0));
        vecs.push_back(v("j10", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h10, 32'h10, 1'b1, 1'b0, 1'b0));
        for (int i = 2; i <= 6; i++)
            vecs.push_back(v("nest_call", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'(16 * i), 32'(16 * i), 1'b0, i >= 5, 1'b0));
        vecs.push_back(v("ret54", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h54, 1'b0, 1'b0, 1'b0));
        vecs.push_back(v("ret44", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h44, 1'b0, 1'b0, 1'b0));
        vecs.push_back(v("ret34", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h34, 1'b0, 1'b0, 1'b0));
        vecs.push_back(v("ret24", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h24, 1'b1, 1'b0, 1'b0));
        vecs.push_back(v("ret_uflow", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h28, 1'b1, 1'b0, 1'b1));
        vecs.push_back(v("uf_clear", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h2C, 1'b1, 1'b0, 1'b0));
        vecs.push_back(v("ret_uflow2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h30, 1'b1, 1'b0, 1'b1));
        vecs.push_back(v("stall_uf0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h30, 1'b1, 1'b0, 1'b0));
        vecs.push_back(v("call900", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h900, 32'h900, 1'b0, 1'b0, 1'b0));
        vecs.push_back(v("br_over_ret", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA00, 32'h0, 32'hA00, 1'b0, 1'b0, 1'b0));
        vecs.push_back(v("ret34b", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h34, 1'b1, 1'b0, 1'b0));
        vecs.push_back(v("callB00", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'hB00, 32'hB00, 1'b0, 1'b0, 1'b0));
        vecs.push_back(v("stall_ret", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'hB00, 1'b0, 1'b0, 1'b0));
        vecs.push_back(v("ret38", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h38, 1'b1, 1'b0, 1'b0));
        vecs.push_back(v("callC00", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'hC00, 32'hC00, 1'b0, 1'b0, 1'b0));
        vecs.push_back(v("callD00", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'hD00, 32'hD00, 1'b0, 1'b0, 1'b0));
        vecs.push_back(v("rst_call", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'hE00, 32'h0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(v("ret_after_rst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h4, 1'b1, 1'b0, 1'b1));
`else
        vecs.push_back(v("call_as_jump", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h400, 32'h400, 1'b1, 1'b0, 1'b0));
        vecs.push_back(v("s404", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h404, 1'b1, 1'b0, 1'b0));
        vecs.push_back(v("ret_ignored", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h408, 1'b1, 1'b0, 1'b0));
        vecs.push_back(v("ret_jmp", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h800, 32'h800, 1'b1, 1'b0, 1'b0));
        vecs.push_back(v("rst_call", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'hE00, 32'h0, 1'b1, 1'b0, 1'b0));
        vecs.push_back(v("seq_after_rst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h4, 1'b1, 1'b0, 1'b0));
`endif

        foreach (vecs[k]) begin
            exp_t e;
            @(negedge clk);
            rst = vecs[k].rst; en = vecs[k].en; br = vecs[k].br;
            jmp = vecs[k].jmp; call = vecs[k].call; ret = vecs[k].ret;
            bt = vecs[k].bt; jt = vecs[k].jt;
            e.name = vecs[k].name; e.out = vecs[k].exp_out;
            e.empty = vecs[k].exp_empty; e.full = vecs[k].exp_full;
            e.uf = vecs[k].exp_uf;
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check({e.name, ".out"}, out_w, e.out);
            check({e.name, ".out_plus_step"}, ops_w, e.out + 32'd4);
            check({e.name, ".ras_empty"}, {31'd0, empty_w}, {31'd0, e.empty});
            check({e.name, ".ras_full"}, {31'd0, full_w}, {31'd0, e.full});
            check({e.name, ".underflow"}, {31'd0, uf_w}, {31'd0, e.uf});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the fetch stage. It generalises the plain PC register with a fixed +4 incrementer into one block that does four things: sequential advance by a configurable step, branch/jump/call redirects with fixed priority, stall, and an optional hardware return-address stack (RAS). It sits at the head of the fetch pipeline and drives the instruction-memory address. All redirect inputs come from decode/execute.

## Interface
Parameters:
- WIDTH, 32, PC and target width in bits
- STEP, 4, sequential increment
- RESET_VECTOR, 0, PC value loaded on reset
- RAS_DEPTH, 4, return-stack entries (power of two, ≥2)

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high; one clock only
- Enable  in  1  advance PC this cycle; 0 = stall, everything holds
- BranchTaken  in  1  redirect to BranchTarget
- BranchTarget  in  WIDTH  branch destination
- Jump  in  1  redirect to JumpTarget
- Call  in  1  redirect to JumpTarget and push Out+STEP
- Return  in  1  redirect to popped RAS entry
- JumpTarget  in  WIDTH  jump/call destination
- Out  out  WIDTH  current PC (registered)
- OutPlusStep  out  WIDTH  Out+STEP (combinational, mod 2^WIDTH)
- RasEmpty  out  1  RAS holds no entries
- RasFull  out  1  RAS holds RAS_DEPTH entries
- Underflow  out  1  registered one-cycle pulse: Return was taken on an empty RAS

## Operation
- Next-PC select, evaluated only when Enable=1, in fixed priority: BranchTaken > Call > Jump > Return > sequential (Out+STEP).
- Only the winning source acts. A losing Call does not push. A losing Return does not pop.
- Call: Out←JumpTarget; push OutPlusStep.
- Return, RAS non-empty: Out←top entry; pop.
- Return, RAS empty: Out←OutPlusStep; no pop; Underflow=1 the next cycle.
- RAS is circular. A push when full overwrites the oldest entry; RasFull stays 1 and the count stays RAS_DEPTH.
- Enable=0: Out, RAS contents, pointer and count hold. All redirects are ignored. Underflow clears to 0.
- Arithmetic wraps modulo 2^WIDTH. No alignment checking: targets are loaded verbatim.

## Timing
- Reset (sync, highest priority, overrides Enable) sets:
  - Out=RESET_VECTOR
  - RAS count=0, RasEmpty=1, RasFull=0
  - Underflow=0
- Reset mid-operation discards all RAS entries.
- Redirect latency: one cycle. Out shows the new target on the edge after the redirect input is sampled with Enable=1.
- OutPlusStep follows Out combinationally in the same cycle.
- RasEmpty and RasFull are derived from the registered count. They update on the same edge as the push or pop.
- Push and pop never happen in the same cycle, because priority makes Call and Return mutually exclusive.

## Configuration
- PC_RAS_EN defined: RAS is built as described above.
- PC_RAS_EN undefined:
  - No RAS storage.
  - Call acts exactly as Jump (no push).
  - Return is ignored; the sequential path or a lower-priority source wins.
  - RasEmpty tied 1, RasFull tied 0, Underflow tied 0.
  - RAS_DEPTH is unused.

## Structure
- Package pc_pkg holds:
  - next-PC select enum: SEL_SEQ, SEL_BRANCH, SEL_CALL, SEL_JUMP, SEL_RETURN
  - default WIDTH/STEP constants
  - a localparam function for log2(RAS_DEPTH)
- Sub-module return_stack (circular LIFO):
  - ports: Clock, Reset, Push, Pop, PushData, Top, Empty, Full
  - instantiated only under PC_RAS_EN
- Incrementer uses the existing ADD module with B=STEP.

## Test plan
- Reset, then Enable=1 for 10 cycles -> Out = 0,4,8,…,36. With Enable=0 for 2 cycles, Out holds at 40.
- Out=0x100, BranchTaken=1 (target 0x200) and Jump=1 (target 0x300) in the same cycle -> Out=0x200; Jump discarded.
- Call to 0x400 from Out=0x100; step 3 cycles; Return -> Out=0x400…0x40C, then 0x104. RasEmpty=1 afterwards.
- Five nested Calls from PCs 0x10,0x20,0x30,0x40,0x50 with RAS_DEPTH=4 -> RasFull=1. Four Returns yield 0x54,0x44,0x34,0x24. Fifth Return -> sequential PC, Underflow pulses 1 cycle.
- Out=0xFFFFFFFC, Enable=1 -> Out=0x00000000.
- Reset asserted with 2 entries on the RAS and Call=1 -> Out=RESET_VECTOR, RasEmpty=1, no push. Same scenario with PC_RAS_EN undefined -> Call lands on JumpTarget, Return ignored.
